// File: rtl/pic_bus_interface.sv
// -----------------------------------------------------------------------------
// pic_bus_interface
//
// Host bus front end of the 8259A PIC. The host strobes (chip_select_n,
// write_n, read_n), A0 and the data byte are registered onto clk. A small bus
// FSM tracks each host cycle. Every completed write produces a one-cycle
// command strobe, and the written byte is held on internal_data_bus.
//
// Parameters
//   DATA_W             width of the host data bus and internal_data_bus (>= 5)
//
// Ports
//   clk                in   system clock, all state updates on the rising edge
//   rst_n              in   synchronous reset, active low
//   chip_select_n      in   host chip select, active low
//   write_n            in   host write strobe, active low
//   read_n             in   host read strobe, active low
//   address            in   A0
//   data_bus_in        in   host data bus
//   internal_data_bus  out  last accepted write byte, held until the next one
//   write_ICW1         out  one-cycle strobe, A0=0 and D4=1
//   write_ICW2_4       out  one-cycle strobe, A0=1
//   write_OCW1         out  one-cycle strobe, A0=1 (fires with write_ICW2_4)
//   write_OCW2         out  one-cycle strobe, A0=0, D4=0, D3=0
//   write_OCW3         out  one-cycle strobe, A0=0, D4=0, D3=1
//   read               out  registered level, host read cycle in progress
//   bus_state          out  FSM state (IDLE=00 WRITE=01 READ=10 ABORT=11)
//
// Configuration macro
//   PIC_BUS_SYNC_EN    when defined, every host input passes through a
//                      two-flop synchroniser instead of a single register,
//                      so an asynchronous host can be used. All latencies
//                      grow by one clock.
// -----------------------------------------------------------------------------
module pic_bus_interface #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chip_select_n,
  input  logic              write_n,
  input  logic              read_n,
  input  logic              address,
  input  logic [DATA_W-1:0] data_bus_in,
  output logic [DATA_W-1:0] internal_data_bus,
  output logic              write_ICW1,
  output logic              write_ICW2_4,
  output logic              write_OCW1,
  output logic              write_OCW2,
  output logic              write_OCW3,
  output logic              read,
  output logic [1:0]        bus_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    ABORT = 2'b11
  } bus_state_t;

  // Strobe vector order: {ICW1, ICW2_4, OCW1, OCW2, OCW3}
  function automatic logic [4:0] decode_cmd(input logic a0, input logic d4,
                                            input logic d3);
    logic [4:0] cmd;
    cmd = 5'b00000;
    if (a0)
      cmd = 5'b01100;
    else if (d4)
      cmd = 5'b10000;
    else if (d3)
      cmd = 5'b00001;
    else
      cmd = 5'b00010;
    return cmd;
  endfunction

  logic              s_cs;
  logic              s_wr;
  logic              s_rd;
  logic              s_a0;
  logic [DATA_W-1:0] s_d;

  // Input register stage. Strobe flops reset to their idle levels, except
  // s_wr which resets low so that reset itself can never arm a write.
`ifdef PIC_BUS_SYNC_EN
  logic              m_cs;
  logic              m_wr;
  logic              m_rd;
  logic              m_a0;
  logic [DATA_W-1:0] m_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_cs <= 1'b1;
      m_wr <= 1'b0;
      m_rd <= 1'b1;
      m_a0 <= 1'b0;
      s_cs <= 1'b1;
      s_wr <= 1'b0;
      s_rd <= 1'b1;
      s_a0 <= 1'b0;
    end else begin
      m_cs <= chip_select_n;
      m_wr <= write_n;
      m_rd <= read_n;
      m_a0 <= address;
      s_cs <= m_cs;
      s_wr <= m_wr;
      s_rd <= m_rd;
      s_a0 <= m_a0;
    end
  end

  always_ff @(posedge clk) begin
    m_d <= data_bus_in;
    s_d <= m_d;
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_cs <= 1'b1;
      s_wr <= 1'b0;
      s_rd <= 1'b1;
      s_a0 <= 1'b0;
    end else begin
      s_cs <= chip_select_n;
      s_wr <= write_n;
      s_rd <= read_n;
      s_a0 <= address;
    end
  end

  always_ff @(posedge clk) begin
    s_d <= data_bus_in;
  end
`endif

  bus_state_t        state;
  bus_state_t        next_state;
  logic              armed;
  logic              cap_a0;
  logic [DATA_W-1:0] cap_d;
  logic              cap_en;
  logic              cap_clr;
  logic              fire;
  logic [4:0]        strobes;

  // A write may only start once write_n has been seen high after reset, so a
  // write held low across reset is routed to ABORT instead of WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n)
      armed <= 1'b0;
    else if (s_wr)
      armed <= 1'b1;
  end

  // Next-state and cycle control
  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    cap_clr    = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (!s_cs && !s_rd) begin
          next_state = READ;
        end else if (!s_cs && !s_wr) begin
          if (armed) begin
            next_state = WRITE;
            cap_en     = 1'b1;
          end else begin
            next_state = ABORT;
          end
        end
      end
      WRITE: begin
        if (!s_rd || (s_cs && !s_wr)) begin
          next_state = ABORT;
          cap_clr    = 1'b1;
        end else if (!s_wr) begin
          cap_en = 1'b1;
        end else begin
          // write_n released: the cycle completes only if CS is still held
          next_state = IDLE;
          fire       = ~s_cs;
        end
      end
      READ: begin
        if (s_rd || s_cs)
          next_state = IDLE;
      end
      ABORT: begin
        if (s_wr && s_rd)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      read  <= 1'b0;
    end else begin
      state <= next_state;
      read  <= (next_state == READ);
    end
  end

  // Captured byte/A0 for the write in progress
  always_ff @(posedge clk) begin
    if (!rst_n || cap_clr) begin
      cap_a0 <= 1'b0;
      cap_d  <= '0;
    end else if (cap_en) begin
      cap_a0 <= s_a0;
      cap_d  <= s_d;
    end
  end

  // Command strobes and data bus, updated on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobes           <= 5'b00000;
      internal_data_bus <= '0;
    end else begin
      strobes <= fire ? decode_cmd(cap_a0, cap_d[4], cap_d[3]) : 5'b00000;
      if (fire)
        internal_data_bus <= cap_d;
    end
  end

  assign write_ICW1   = strobes[4];
  assign write_ICW2_4 = strobes[3];
  assign write_OCW1   = strobes[2];
  assign write_OCW2   = strobes[1];
  assign write_OCW3   = strobes[0];
  assign bus_state    = state;

endmodule
